vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 167 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync timing receiver: line/frame measurement, pixel coordinates, lock detection
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic       locked,
  output logic       timing_err
);

  localparam logic [9:0] H_TOTAL_W  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_W  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACTIVE_W = 10'(H_ACTIVE);
  localparam logic [2:0] LOCK_W     = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t     state;
  logic [2:0] match_cnt;
  logic       h_prev, v_prev, de_prev;
  logic [9:0] h_cnt, v_cnt, x_cnt, y_cnt, de_len;

  logic       h_fall, v_fall, de_fall, watchdog;
  logic [9:0] h_meas_nxt, v_cnt_line, v_meas_nxt, de_len_nxt;
  logic       frame_good, lock_err;

  assign h_fall  = pclk_en & h_prev & ~h_sync;
  assign v_fall  = pclk_en & v_prev & ~v_sync;
  assign de_fall = pclk_en & de_prev & ~DE;

  // v_cnt_line already includes a line ending on this very sample, so a
  // coincident h/v fall is counted in the frame it closes.
  assign h_meas_nxt = h_fall ? ((&h_cnt) ? 10'd1023 : h_cnt + 10'd1) : h_meas;
  assign v_cnt_line = (h_fall && !(&v_cnt)) ? v_cnt + 10'd1 : v_cnt;
  assign v_meas_nxt = v_fall ? v_cnt_line : v_meas;
  assign de_len_nxt = de_fall ? x_cnt : de_len;
  assign watchdog   = pclk_en & ~h_fall & (h_cnt == 10'd1022);

  assign frame_good = (v_meas_nxt == V_TOTAL_W) && (h_meas_nxt == H_TOTAL_W);
  assign lock_err   = (h_fall && h_meas_nxt != H_TOTAL_W) ||
                      (de_fall && de_len_nxt != H_ACTIVE_W) ||
                      (v_fall && v_meas_nxt != V_TOTAL_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      de_prev     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      de_len      <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pclk_en) begin
        h_prev      <= h_sync;
        v_prev      <= v_sync;
        de_prev     <= DE;
        line_start  <= h_fall;
        frame_start <= v_fall;
        h_meas      <= h_meas_nxt;
        v_meas      <= v_meas_nxt;
        de_len      <= de_len_nxt;

        if (h_fall)
          h_cnt <= '0;
        else if (!(&h_cnt))
          h_cnt <= h_cnt + 10'd1;

        v_cnt <= v_fall ? 10'd0 : v_cnt_line;

        if (DE) begin
          pix_valid <= 1'b1;
          x_pixel   <= x_cnt;
          y_pixel   <= y_cnt;
          if (!(&x_cnt))
            x_cnt <= x_cnt + 10'd1;
        end else if (de_fall) begin
          x_cnt <= '0;
        end

        // A frame boundary wins over the line advance of a same-sample DE fall.
        if (v_fall)
          y_cnt <= '0;
        else if (de_fall && !(&y_cnt))
          y_cnt <= y_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      if (watchdog) begin
        state      <= SEARCH;
        match_cnt  <= '0;
        locked     <= 1'b0;
        timing_err <= (state == LOCKED);
      end else if (pclk_en) begin
        case (state)
          SEARCH: begin
            if (v_fall) begin
              state     <= MEASURE;
              match_cnt <= '0;
            end
          end
          MEASURE: begin
            if (v_fall) begin
              if (frame_good) begin
                match_cnt <= match_cnt + 3'd1;
                if (match_cnt + 3'd1 == LOCK_W) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (lock_err) begin
              state      <= MEASURE;
              match_cnt  <= '0;
              locked     <= 1'b0;
              timing_err <= 1'b1;
            end
          end
          default: begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver on a scaled 20x12 raster
module tb_vga_sync_receiver;

  localparam int HT = 20;
  localparam int VT = 12;
  localparam int HA = 12;
  localparam int VA = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       pclk_en;
  logic       h_sync;
  logic       v_sync;
  logic       DE;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       pix_valid;
  logic       line_start;
  logic       frame_start;
  logic [9:0] h_meas;
  logic [9:0] v_meas;
  logic       locked;
  logic       timing_err;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pclk_en(pclk_en),
    .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start),
    .h_meas(h_meas), .v_meas(v_meas),
    .locked(locked), .timing_err(timing_err)
  );

  int         n_pix = 0;
  int         n_ls  = 0;
  int         n_fs  = 0;
  int         n_te  = 0;
  logic [9:0] px_x [0:4095];
  logic [9:0] px_y [0:4095];

  // Pulses are sampled mid-cycle, away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (pix_valid) begin
      if (n_pix < 4096) begin
        px_x[n_pix] <= x_pixel;
        px_y[n_pix] <= y_pixel;
      end
      n_pix <= n_pix + 1;
    end
    if (line_start)  n_ls <= n_ls + 1;
    if (frame_start) n_fs <= n_fs + 1;
    if (timing_err)  n_te <= n_te + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_pixel(input logic hs, input logic vs, input logic de);
    @(negedge clk);
    h_sync  = hs;
    v_sync  = vs;
    DE      = de;
    pclk_en = 1'b1;
    @(negedge clk);
    pclk_en = 1'b0;
  endtask

  // coinc moves the v_sync fall onto the h_sync fall of line 10.
  task automatic send_line(input int l, input int p0, input int p1, input bit coinc);
    for (int p = p0; p <= p1; p++) begin
      logic hs, vs, de;
      hs = !(p >= 14 && p <= 16);
      vs = coinc ? !((l == 10 && p >= 14) || l == 11) : !(l == 10 || l == 11);
      de = (l < VA) && (p < HA);
      send_pixel(hs, vs, de);
    end
  endtask

  task automatic send_frame(input int short_line, input bit coinc);
    for (int l = 0; l < VT; l++)
      send_line(l, 0, (l == short_line) ? HT - 2 : HT - 1, coinc);
  endtask

  typedef struct {
    string name;
    int    short_line;
    int    exp_locked;
    int    exp_te;
    int    exp_pix;
    int    fx, fy, lx, ly;
    int    exp_h, exp_v;
  } vec_t;

  vec_t vecs [5];
  int   b_pix, b_ls, b_fs, b_te;

  initial begin
    vecs[0] = '{"locked_frame", -1, 1, 0, 96, 0, 0, 11, 7, 20, 12};
    vecs[1] = '{"short_line",   10, 0, 1, 96, 0, 0, 11, 7, 19, 12};
    vecs[2] = '{"relock_1",     -1, 0, 0, 96, 0, 0, 11, 7, 20, 12};
    vecs[3] = '{"relock_2",     -1, 1, 0, 96, 0, 0, 11, 7, 20, 12};
    vecs[4] = '{"still_locked", -1, 1, 0, 96, 0, 0, 11, 7, 20, 12};

    reset   = 1'b1;
    pclk_en = 1'b0;
    h_sync  = 1'b1;
    v_sync  = 1'b1;
    DE      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {22'd0, x_pixel, y_pixel, h_meas, v_meas, pix_valid, line_start, frame_start, locked, timing_err},
          32'd0);
    reset = 1'b0;

    // Lock comes exactly at the v_sync fall closing the second frame after the first fall.
    send_frame(-1, 0);
    send_frame(-1, 0);
    check("no_lock_after_2_frames", locked, 0);
    for (int l = 0; l < 10; l++) send_line(l, 0, HT - 1, 0);
    check("no_lock_before_vfall", locked, 0);
    send_line(10, 0, 0, 0);
    check("lock_at_vfall", locked, 1);
    check("lock_h_meas", h_meas, HT);
    check("lock_v_meas", v_meas, VT);
    send_line(10, 1, HT - 1, 0);
    send_line(11, 0, HT - 1, 0);

    foreach (vecs[i]) begin
      b_pix = n_pix; b_ls = n_ls; b_fs = n_fs; b_te = n_te;
      send_frame(vecs[i].short_line, 0);
      check({vecs[i].name, "_locked"}, locked, vecs[i].exp_locked);
      check({vecs[i].name, "_timing_err"}, n_te - b_te, vecs[i].exp_te);
      check({vecs[i].name, "_pix_count"}, n_pix - b_pix, vecs[i].exp_pix);
      check({vecs[i].name, "_first_x"}, px_x[b_pix], vecs[i].fx);
      check({vecs[i].name, "_first_y"}, px_y[b_pix], vecs[i].fy);
      check({vecs[i].name, "_last_x"}, px_x[n_pix - 1], vecs[i].lx);
      check({vecs[i].name, "_last_y"}, px_y[n_pix - 1], vecs[i].ly);
      check({vecs[i].name, "_h_meas"}, h_meas, vecs[i].exp_h);
      check({vecs[i].name, "_v_meas"}, v_meas, vecs[i].exp_v);
      check({vecs[i].name, "_line_starts"}, n_ls - b_ls, VT);
      check({vecs[i].name, "_frame_starts"}, n_fs - b_fs, 1);
    end

    // Watchdog: h_cnt is 5 after a full frame, so it reaches 1023 on the 1018th held pixel.
    b_te = n_te;
    repeat (1017) send_pixel(1'b1, 1'b1, 1'b0);
    check("wd_before_limit", locked, 1);
    send_pixel(1'b1, 1'b1, 1'b0);
    check("wd_drops_lock", locked, 0);
    check("wd_timing_err", n_te - b_te, 1);
    repeat (82) send_pixel(1'b1, 1'b1, 1'b0);
    check("wd_single_err", n_te - b_te, 1);
    send_frame(-1, 0);
    send_frame(-1, 0);
    check("wd_search_2_frames", locked, 0);
    send_frame(-1, 0);
    check("wd_search_relock", locked, 1);

    // Coincident h/v fall: the closing line counts, and v_cnt restarts from 0.
    b_te = n_te;
    send_frame(-1, 1);
    check("coinc_v_meas_plus1", v_meas, VT + 1);
    check("coinc_timing_err", n_te - b_te, 1);
    check("coinc_unlocked", locked, 0);
    b_pix = n_pix;
    send_frame(-1, 1);
    check("coinc_v_meas_again", v_meas, VT);
    check("coinc_first_x", px_x[b_pix], 0);
    check("coinc_first_y", px_y[b_pix], 0);
    check("coinc_no_new_err", n_te - b_te, 1);

    // Reset mid-line while a pixel pulse is on the outputs.
    send_line(0, 0, HT - 1, 0);
    send_line(1, 0, HT - 1, 0);
    send_line(2, 0, 5, 0);
    check("pre_reset_valid", pix_valid, 1);
    check("pre_reset_x", x_pixel, 5);
    #2 reset = 1'b1;
    #1;
    check("reset_async",
          {22'd0, x_pixel, y_pixel, h_meas, v_meas, pix_valid, line_start, frame_start, locked, timing_err},
          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b_pix = n_pix; b_ls = n_ls; b_fs = n_fs;
    send_line(2, 6, 13, 0);
    check("post_reset_no_line_start", n_ls - b_ls, 0);
    check("post_reset_no_frame_start", n_fs - b_fs, 0);
    check("post_reset_pix_count", n_pix - b_pix, 6);
    check("post_reset_first_x", px_x[b_pix], 0);
    check("post_reset_first_y", px_y[b_pix], 0);
    send_line(2, 14, HT - 1, 0);
    for (int l = 3; l < VT; l++) send_line(l, 0, HT - 1, 0);
    check("post_reset_partial", locked, 0);
    send_frame(-1, 0);
    check("post_reset_1_frame", locked, 0);
    send_frame(-1, 0);
    check("post_reset_relock", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
